// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite animation engine.
package sprite_pkg;

    typedef enum logic [1:0] {
        ANIM_LOOP     = 2'b00,
        ANIM_PINGPONG = 2'b01,
        ANIM_ONESHOT  = 2'b10
    } anim_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } anim_dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/sprite_anim_seq.sv
// Frame-rate tick synchroniser and animation frame sequencer (loop / ping-pong / one-shot).
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int MAX_FRAMES = 4,
    parameter int HOLD_W     = 6,
    parameter int ADDR_W     = 14,
    localparam int FRAME_W   = $clog2(MAX_FRAMES)
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               frame_clk,
    input  logic [3:0]         anim_id,
    input  logic [FRAME_W:0]   anim_len,
    input  logic [HOLD_W-1:0]  anim_hold,
    input  logic [1:0]         anim_mode,
    input  logic [ADDR_W-1:0]  anim_base,
    output logic [FRAME_W-1:0] frame_num,
    output logic               anim_done,
    output logic [ADDR_W-1:0]  base_q
);

    logic [2:0]         sync_q;
    logic               tick;
    logic [3:0]         cur_id;
    logic [FRAME_W-1:0] last_q;
    logic [HOLD_W-1:0]  hold_m1_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [1:0]         mode_q;
    anim_dir_t          dir;

    logic [FRAME_W-1:0] len_m1;
    logic [HOLD_W-1:0]  hold_m1;

    // Clamp the descriptor once, at latch time, so the stepping logic sees legal values only.
    always_comb begin
        len_m1 = '0;
        if (anim_len > (FRAME_W+1)'(MAX_FRAMES))
            len_m1 = FRAME_W'(MAX_FRAMES - 1);
        else if (anim_len != '0)
            len_m1 = FRAME_W'(anim_len - 1'b1);
        hold_m1 = (anim_hold == '0) ? '0 : anim_hold - 1'b1;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            tick      <= 1'b0;
            cur_id    <= '0;
            last_q    <= '0;
            hold_m1_q <= '0;
            hold_cnt  <= '0;
            mode_q    <= ANIM_LOOP;
            base_q    <= '0;
            frame_num <= '0;
            anim_done <= 1'b0;
            dir       <= DIR_UP;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk};
            tick   <= sync_q[1] & ~sync_q[2];
            if (tick) begin
                if (anim_id != cur_id) begin
                    cur_id    <= anim_id;
                    last_q    <= len_m1;
                    hold_m1_q <= hold_m1;
                    mode_q    <= anim_mode;
                    base_q    <= anim_base;
                    frame_num <= '0;
                    hold_cnt  <= '0;
                    dir       <= DIR_UP;
                    anim_done <= 1'b0;
                end else if (hold_cnt != hold_m1_q) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end else begin
                    hold_cnt <= '0;
                    case (mode_q)
                        ANIM_PINGPONG: begin
                            // End frames are shown once: bounce straight to the neighbour.
                            if (last_q == '0) begin
                                frame_num <= '0;
                            end else if (dir == DIR_UP) begin
                                if (frame_num == last_q) begin
                                    frame_num <= frame_num - 1'b1;
                                    dir       <= DIR_DOWN;
                                end else begin
                                    frame_num <= frame_num + 1'b1;
                                end
                            end else begin
                                if (frame_num == '0) begin
                                    frame_num <= FRAME_W'(1);
                                    dir       <= DIR_UP;
                                end else begin
                                    frame_num <= frame_num - 1'b1;
                                end
                            end
                        end
                        ANIM_ONESHOT: begin
                            if (frame_num == last_q) begin
                                anim_done <= 1'b1;
                            end else begin
                                frame_num <= frame_num + 1'b1;
                                anim_done <= (frame_num + 1'b1 == last_q);
                            end
                        end
                        default: begin
                            frame_num <= (frame_num == last_q) ? '0 : frame_num + 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/sprite_animator.sv
// Sprite animation engine: box test, mirrored ROM addressing and transparency-keyed pixel output.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 50,
    parameter int SPR_H      = 64,
    parameter int MAX_FRAMES = 4,
    parameter int HOLD_W     = 6,
    parameter int IDX_W      = 3,
    parameter int KEY_IDX    = 0,
    parameter int ADDR_W     = $clog2(MAX_FRAMES*SPR_W*SPR_H),
    localparam int FRAME_W   = $clog2(MAX_FRAMES)
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               frame_clk,
    input  logic [3:0]         anim_id,
    input  logic [FRAME_W:0]   anim_len,
    input  logic [HOLD_W-1:0]  anim_hold,
    input  logic [1:0]         anim_mode,
    input  logic [ADDR_W-1:0]  anim_base,
    input  logic               mirror,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    input  logic               blank,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [IDX_W-1:0]   rom_q,
    output logic               pix_on,
    output logic [IDX_W-1:0]   pix_idx,
    output logic [FRAME_W-1:0] frame_num,
    output logic               anim_done
);

    localparam int FRAME_SZ = SPR_W * SPR_H;

    logic [ADDR_W-1:0] base_q;

    sprite_anim_seq #(
        .MAX_FRAMES (MAX_FRAMES),
        .HOLD_W     (HOLD_W),
        .ADDR_W     (ADDR_W)
    ) u_seq (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .frame_clk (frame_clk),
        .anim_id   (anim_id),
        .anim_len  (anim_len),
        .anim_hold (anim_hold),
        .anim_mode (anim_mode),
        .anim_base (anim_base),
        .frame_num (frame_num),
        .anim_done (anim_done),
        .base_q    (base_q)
    );

    // Offsets are 11-bit two's complement so sprites near the screen edge never wrap into the box.
    logic [10:0]       x_off;
    logic [10:0]       y_off;
    logic [10:0]       x_m;
    logic              in_box;
    logic [ADDR_W-1:0] addr_n;

    always_comb begin
        x_off  = {1'b0, draw_x} - {1'b0, pos_x} + 11'(SPR_W / 2);
        y_off  = {1'b0, draw_y} - {1'b0, pos_y} + 11'(SPR_H / 2);
        in_box = !x_off[10] && (x_off < 11'(SPR_W)) &&
                 !y_off[10] && (y_off < 11'(SPR_H));
        x_m    = mirror ? 11'(SPR_W - 1) - x_off : x_off;
        addr_n = base_q
               + ADDR_W'(frame_num) * ADDR_W'(FRAME_SZ)
               + ADDR_W'(y_off) * ADDR_W'(SPR_W)
               + ADDR_W'(x_m);
    end

    logic in_box_r, blank_r;
    logic in_box_q, blank_q;
    logic opaque;

    assign opaque = in_box_q & blank_q & (rom_q != IDX_W'(KEY_IDX));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            in_box_r <= 1'b0;
            blank_r  <= 1'b0;
            in_box_q <= 1'b0;
            blank_q  <= 1'b0;
            pix_on   <= 1'b0;
            pix_idx  <= '0;
        end else begin
            rom_addr <= in_box ? addr_n : '0;
            in_box_r <= in_box;
            blank_r  <= blank;
            // Second copy lines the box/blank flags up with rom_q from the synchronous ROM.
            in_box_q <= in_box_r;
            blank_q  <= blank_r;
            pix_on   <= opaque;
            pix_idx  <= opaque ? rom_q : '0;
        end
    end

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: frame sequencer sequences plus a queued pixel-pipeline scoreboard.
module tb_sprite_animator;

    localparam int ADDR_W  = 14;
    localparam int IDX_W   = 3;
    localparam int FRAME_W = 2;
    localparam int HOLD_W  = 6;

    logic               vga_clk = 1'b0;
    logic               reset_n;
    logic               frame_clk;
    logic [3:0]         anim_id;
    logic [FRAME_W:0]   anim_len;
    logic [HOLD_W-1:0]  anim_hold;
    logic [1:0]         anim_mode;
    logic [ADDR_W-1:0]  anim_base;
    logic               mirror;
    logic [9:0]         pos_x, pos_y, draw_x, draw_y;
    logic               blank;
    logic [ADDR_W-1:0]  rom_addr;
    logic [IDX_W-1:0]   rom_q = '0;
    logic               pix_on;
    logic [IDX_W-1:0]   pix_idx;
    logic [FRAME_W-1:0] frame_num;
    logic               anim_done;

    sprite_animator dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .frame_clk (frame_clk),
        .anim_id   (anim_id),
        .anim_len  (anim_len),
        .anim_hold (anim_hold),
        .anim_mode (anim_mode),
        .anim_base (anim_base),
        .mirror    (mirror),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .draw_x    (draw_x),
        .draw_y    (draw_y),
        .blank     (blank),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .pix_on    (pix_on),
        .pix_idx   (pix_idx),
        .frame_num (frame_num),
        .anim_done (anim_done)
    );

    // clock / reset block
    always #5 vga_clk = ~vga_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ROM contents: low address bits, so every 8th word is the transparent key.
    function automatic logic [IDX_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    always @(posedge vga_clk) rom_q <= rom_fn(rom_addr);

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // driver tasks
    task automatic set_anim(input logic [3:0] id, input logic [FRAME_W:0] len,
                            input logic [HOLD_W-1:0] hold, input logic [1:0] mode,
                            input logic [ADDR_W-1:0] base);
        anim_id = id; anim_len = len; anim_hold = hold; anim_mode = mode; anim_base = base;
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        repeat (3) @(negedge vga_clk);
        frame_clk = 1'b0;
        repeat (5) @(negedge vga_clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rom_addr"},  32'(rom_addr),  0);
        chk({tag, "_pix_on"},    32'(pix_on),    0);
        chk({tag, "_pix_idx"},   32'(pix_idx),   0);
        chk({tag, "_frame_num"}, 32'(frame_num), 0);
        chk({tag, "_anim_done"}, 32'(anim_done), 0);
    endtask

    typedef struct {
        logic [9:0]        dx, dy, px, py;
        logic              mir, blk, inb;
        logic [ADDR_W-1:0] addr;
    } pix_vec_t;

    localparam int NV = 13;
    pix_vec_t vecs[NV];

    task automatic set_vec(input int i, input logic [9:0] dx, input logic [9:0] dy,
                           input logic [9:0] px, input logic [9:0] py, input logic mir,
                           input logic blk, input logic inb, input logic [ADDR_W-1:0] addr);
        vecs[i].dx = dx; vecs[i].dy = dy; vecs[i].px = px; vecs[i].py = py;
        vecs[i].mir = mir; vecs[i].blk = blk; vecs[i].inb = inb; vecs[i].addr = addr;
    endtask

    // scoreboard queues
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [IDX_W:0]    exp_pix_q[$];

    initial begin
        logic [FRAME_W-1:0] pp_seq[5];
        logic [ADDR_W-1:0]  ea;
        logic [IDX_W:0]     ep;
        logic               on;

        // base 100, frame 1 -> frame offset 3300
        set_vec(0,  10'd75,  10'd68,  10'd100, 10'd100, 1'b0, 1'b1, 1'b1, 14'd3300);
        set_vec(1,  10'd75,  10'd68,  10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 14'd3349);
        set_vec(2,  10'd76,  10'd70,  10'd100, 10'd100, 1'b0, 1'b1, 1'b1, 14'd3401);
        set_vec(3,  10'd76,  10'd70,  10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 14'd3448);
        set_vec(4,  10'd125, 10'd100, 10'd100, 10'd100, 1'b0, 1'b1, 1'b0, 14'd0);
        set_vec(5,  10'd124, 10'd100, 10'd100, 10'd100, 1'b0, 1'b1, 1'b1, 14'd4949);
        set_vec(6,  10'd0,   10'd100, 10'd10,  10'd100, 1'b0, 1'b1, 1'b1, 14'd4915);
        set_vec(7,  10'd0,   10'd100, 10'd10,  10'd100, 1'b0, 1'b0, 1'b1, 14'd4915);
        set_vec(8,  10'd0,   10'd100, 10'd30,  10'd100, 1'b0, 1'b1, 1'b0, 14'd0);
        set_vec(9,  10'd100, 10'd132, 10'd100, 10'd100, 1'b0, 1'b1, 1'b0, 14'd0);
        set_vec(10, 10'd100, 10'd68,  10'd100, 10'd100, 1'b0, 1'b1, 1'b1, 14'd3325);
        set_vec(11, 10'd100, 10'd68,  10'd100, 10'd100, 1'b1, 1'b1, 1'b1, 14'd3324);
        set_vec(12, 10'd639, 10'd100, 10'd10,  10'd100, 1'b0, 1'b1, 1'b0, 14'd0);

        pp_seq[0] = 2'd2; pp_seq[1] = 2'd1; pp_seq[2] = 2'd0; pp_seq[3] = 2'd1; pp_seq[4] = 2'd2;

        reset_n = 1'b0; frame_clk = 1'b0;
        set_anim(4'd0, '0, '0, 2'd0, '0);
        mirror = 1'b0; pos_x = 10'd500; pos_y = 10'd400; draw_x = '0; draw_y = '0; blank = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge vga_clk);

        // loop, len 3, hold 6
        set_anim(4'd1, 3'd3, 6'd6, 2'b00, '0);
        frame_tick();
        chk("loop_start", 32'(frame_num), 0);
        for (int k = 1; k <= 40; k++) begin
            frame_tick();
            chk("loop_frame", 32'(frame_num), 32'((k / 6) % 3));
        end

        // len 7 clamps to 4 frames, hold 0 clamps to 1
        set_anim(4'd8, 3'd7, 6'd0, 2'b11, '0);
        frame_tick();
        for (int k = 1; k <= 5; k++) begin
            frame_tick();
            chk("clamp_frame", 32'(frame_num), 32'(k % 4));
        end

        // ping-pong, len 3, hold 1, with tick latency check on the first step
        set_anim(4'd2, 3'd3, 6'd1, 2'b01, '0);
        frame_tick();
        chk("pp_start", 32'(frame_num), 0);
        frame_clk = 1'b1;
        repeat (3) @(negedge vga_clk);
        chk("tick_latency_early", 32'(frame_num), 0);
        @(negedge vga_clk);
        chk("tick_latency", 32'(frame_num), 1);
        frame_clk = 1'b0;
        repeat (4) @(negedge vga_clk);
        for (int i = 0; i < 5; i++) begin
            frame_tick();
            chk("pp_frame", 32'(frame_num), 32'(pp_seq[i]));
        end

        // reset mid ping-pong with an in-box pixel being driven
        pos_x = 10'd100; pos_y = 10'd100; draw_x = 10'd124; draw_y = 10'd100; blank = 1'b1;
        repeat (4) @(negedge vga_clk);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("reset_mid");
        @(negedge vga_clk);
        reset_n = 1'b1;
        pos_x = 10'd500; pos_y = 10'd400; draw_x = '0; draw_y = '0; blank = 1'b0;
        frame_tick();
        chk("rst_restart", 32'(frame_num), 0);
        frame_tick();
        chk("rst_pp_1", 32'(frame_num), 1);
        frame_tick();
        chk("rst_pp_2", 32'(frame_num), 2);
        frame_tick();
        chk("rst_pp_3", 32'(frame_num), 1);

        // one-shot, len 2, hold 2
        set_anim(4'd3, 3'd2, 6'd2, 2'b10, '0);
        frame_tick();
        chk("os_start_frame", 32'(frame_num), 0);
        chk("os_start_done",  32'(anim_done), 0);
        frame_tick();
        chk("os_t1_frame", 32'(frame_num), 0);
        chk("os_t1_done",  32'(anim_done), 0);
        frame_tick();
        chk("os_t2_frame", 32'(frame_num), 1);
        chk("os_t2_done",  32'(anim_done), 1);
        anim_len = 3'd4;
        frame_tick();
        frame_tick();
        chk("os_hold_frame", 32'(frame_num), 1);
        chk("os_hold_done",  32'(anim_done), 1);
        set_anim(4'd4, 3'd2, 6'd2, 2'b10, '0);
        frame_tick();
        chk("os_new_id_frame", 32'(frame_num), 0);
        chk("os_new_id_done",  32'(anim_done), 0);

        // id change on the same tick as a hold expiry
        set_anim(4'd6, 3'd3, 6'd2, 2'b00, '0);
        frame_tick();
        frame_tick();
        frame_tick();
        chk("expiry_pre_step", 32'(frame_num), 1);
        frame_tick();
        set_anim(4'd7, 3'd3, 6'd2, 2'b00, '0);
        frame_tick();
        chk("expiry_id_change", 32'(frame_num), 0);
        frame_tick();
        chk("expiry_after_1", 32'(frame_num), 0);
        frame_tick();
        chk("expiry_after_2", 32'(frame_num), 1);

        // pixel pipeline: one-shot parked on frame 1 at base 100
        set_anim(4'd5, 3'd2, 6'd1, 2'b10, 14'd100);
        frame_tick();
        frame_tick();
        chk("pix_setup_frame", 32'(frame_num), 1);
        chk("pix_setup_done",  32'(anim_done), 1);

        for (int c = 0; c < NV + 3; c++) begin
            @(negedge vga_clk);
            if (c >= 1 && c - 1 < NV) begin
                if (exp_addr_q.size() == 0) chk("addr_q_empty", 1, 0);
                else begin
                    ea = exp_addr_q.pop_front();
                    chk("rom_addr", 32'(rom_addr), 32'(ea));
                end
            end
            if (c >= 3) begin
                if (exp_pix_q.size() == 0) chk("pix_q_empty", 1, 0);
                else begin
                    ep = exp_pix_q.pop_front();
                    chk("pix_on",  32'(pix_on),  32'(ep[IDX_W]));
                    chk("pix_idx", 32'(pix_idx), 32'(ep[IDX_W-1:0]));
                end
            end
            if (c < NV) begin
                draw_x = vecs[c].dx; draw_y = vecs[c].dy;
                pos_x  = vecs[c].px; pos_y  = vecs[c].py;
                mirror = vecs[c].mir; blank = vecs[c].blk;
                on = vecs[c].inb & vecs[c].blk & (rom_fn(vecs[c].addr) != '0);
                exp_addr_q.push_back(vecs[c].addr);
                exp_pix_q.push_back({on, on ? rom_fn(vecs[c].addr) : 3'd0});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
